// File: rtl/branch_pkg.sv
// Shared definitions for the branch sequencer: opcodes, FSM state encoding, link register.
package branch_pkg;

    localparam logic [5:0] OP_BEQ  = 6'd14;
    localparam logic [5:0] OP_BNE  = 6'd15;
    localparam logic [5:0] OP_BGT  = 6'd16;
    localparam logic [5:0] OP_BGE  = 6'd17;
    localparam logic [5:0] OP_BLT  = 6'd18;
    localparam logic [5:0] OP_BLE  = 6'd19;
    localparam logic [5:0] OP_J    = 6'd20;
    localparam logic [5:0] OP_JR   = 6'd21;
    localparam logic [5:0] OP_JAL  = 6'd22;
    localparam logic [5:0] OP_HALT = 6'd63;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        RESOLVE,
        UPDATE,
        HALT
    } branch_state_t;

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch/jump resolution: picks the next PC from opcode, operands and immediate.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int PC_W = 9
) (
    input  logic [5:0]      opcode,
    input  logic [31:0]     a,
    input  logic [31:0]     b,
    input  logic [PC_W-1:0] pc,
    input  logic [15:0]     imm16,
    output logic [PC_W-1:0] next_pc,
    output logic            taken,
    output logic            is_jal
);

    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] imm_ext;
    logic [PC_W-1:0] cond_tgt;
    logic            cond;

    // Sign-extended so a negative offset still works if PC_W exceeds 16; all sums wrap at PC_W.
    assign imm_ext  = PC_W'($signed(imm16));
    assign seq_pc   = pc + 1'b1;
    assign cond_tgt = seq_pc + imm_ext;

    always_comb begin
        cond    = 1'b0;
        next_pc = seq_pc;
        taken   = 1'b0;
        is_jal  = 1'b0;
        case (opcode)
            OP_BEQ:  cond = (a == b);
            OP_BNE:  cond = (a != b);
            OP_BGT:  cond = (a >  b);
            OP_BGE:  cond = (a >= b);
            OP_BLT:  cond = (a <  b);
            OP_BLE:  cond = (a <= b);
            default: cond = 1'b0;
        endcase
        if (cond) begin
            next_pc = cond_tgt;
            taken   = 1'b1;
        end
        case (opcode)
            OP_J: begin
                next_pc = imm_ext;
                taken   = 1'b1;
            end
            OP_JR: begin
                next_pc = a[PC_W-1:0];
                taken   = 1'b1;
            end
            OP_JAL: begin
                next_pc = imm_ext;
                taken   = 1'b1;
                is_jal  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_seq_ctrl.sv
// PC sequencer: fetch, decode, resolve, update. Optional counters under BRANCH_SEQ_CTRL_STATS_EN.
module branch_seq_ctrl
    import branch_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [5:0]      HALT_OP  = OP_HALT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic [4:0]      rf_raddr_a,
    output logic [4:0]      rf_raddr_b,
    input  logic [31:0]     rf_rdata_a,
    input  logic [31:0]     rf_rdata_b,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [31:0]     rf_wdata,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            taken,
`ifdef BRANCH_SEQ_CTRL_STATS_EN
    output logic [31:0]     retired_cnt,
    output logic [31:0]     taken_cnt,
`endif
    output branch_state_t   dbg_state
);

    // imem handshake: imem_req stays high for the whole FETCH state; the
    // instruction is taken in the single cycle where imem_req && imem_ack.

    branch_state_t   state, state_n;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_inc;
    logic [31:0]     ir;
    logic [PC_W-1:0] next_pc_q;
    logic            taken_q;
    logic            jal_q;
    logic [31:0]     wdata_q;

    logic [PC_W-1:0] res_pc;
    logic            res_taken;
    logic            res_jal;

    assign pc_inc = pc_q + 1'b1;

    branch_resolve #(.PC_W(PC_W)) u_resolve (
        .opcode  (ir[31:26]),
        .a       (rf_rdata_a),
        .b       (rf_rdata_b),
        .pc      (pc_q),
        .imm16   (ir[15:0]),
        .next_pc (res_pc),
        .taken   (res_taken),
        .is_jal  (res_jal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc_q      <= RESET_PC;
            ir        <= '0;
            next_pc_q <= RESET_PC;
            taken_q   <= 1'b0;
            jal_q     <= 1'b0;
            wdata_q   <= '0;
        end else begin
            state <= state_n;
            case (state)
                FETCH: if (imem_ack) ir <= imem_data;
                RESOLVE: begin
                    next_pc_q <= res_pc;
                    taken_q   <= res_taken;
                    jal_q     <= res_jal;
                    if (res_jal) wdata_q <= 32'(pc_inc);
                end
                UPDATE: pc_q <= next_pc_q;
                // HALT did not advance the PC, so restart fetches the word after it.
                HALT: if (start) pc_q <= pc_inc;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = FETCH;
            FETCH:   if (imem_ack) state_n = DECODE;
            DECODE:  state_n = (ir[31:26] == HALT_OP) ? HALT : RESOLVE;
            RESOLVE: state_n = UPDATE;
            UPDATE:  state_n = FETCH;
            HALT:    if (start) state_n = FETCH;
            default: state_n = IDLE;
        endcase
    end

    assign imem_req   = (state == FETCH);
    assign imem_addr  = imem_req ? pc_q : '0;
    assign rf_raddr_a = ir[25:21];
    assign rf_raddr_b = ir[20:16];
    assign rf_we      = (state == UPDATE) && jal_q;
    assign rf_waddr   = LINK_REG;
    assign rf_wdata   = wdata_q;
    assign pc         = pc_q;
    assign busy       = (state != IDLE) && (state != HALT);
    assign halted     = (state == HALT);
    assign taken      = (state == UPDATE) && taken_q;
    assign dbg_state  = state;

`ifdef BRANCH_SEQ_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt <= '0;
            taken_cnt   <= '0;
        end else begin
            if (state == UPDATE) retired_cnt <= retired_cnt + 1'b1;
            if (taken)           taken_cnt   <= taken_cnt + 1'b1;
        end
    end
`endif

endmodule
